dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 256x32 data memory of the RISC_V core. It shares the single memory port between the core load/store unit (port 0) and a DMA/debug master (port 1) with round-robin priority. It drives the memory address, write-enable and write-data lines, and returns read data with a one-cycle done pulse per access. It sits between the LSU/DMA masters and the data memory instance.

---
 rtl/dmem_arbiter_if.sv | 54 +++++
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the two requester ports (LSU = port 0, DMA/debug = port 1) and the
//   data-memory port that the arbiter drives.
//
//   Requester side : req_x, we_x, addr_x, wdata_x  -> arbiter
//                    gnt_x, done_x, rdata_x        <- arbiter
//   Status         : busy                          <- arbiter
//   Memory side    : addr_data_m, mem_we, in_data_m <- arbiter
//                    out_data_m                     -> arbiter
//
//   slave  : view taken by the arbiter
//   master : view taken by whatever drives the requests and models the memory
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              req_0;
  logic              req_1;
  logic              we_0;
  logic              we_1;
  logic [ADDR_W-1:0] addr_0;
  logic [ADDR_W-1:0] addr_1;
  logic [DATA_W-1:0] wdata_0;
  logic [DATA_W-1:0] wdata_1;

  logic              gnt_0;
  logic              gnt_1;
  logic              done_0;
  logic              done_1;
  logic [DATA_W-1:0] rdata_0;
  logic [DATA_W-1:0] rdata_1;
  logic              busy;

  logic [ADDR_W-1:0] addr_data_m;
  logic              mem_we;
  logic [DATA_W-1:0] in_data_m;
  logic [DATA_W-1:0] out_data_m;

  modport slave (
    input  req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    input  out_data_m,
    output gnt_0, gnt_1, done_0, done_1, rdata_0, rdata_1, busy,
    output addr_data_m, mem_we, in_data_m
  );

  modport master (
    output req_0, req_1, we_0, we_1, addr_0, addr_1, wdata_0, wdata_1,
    output out_data_m,
    input  gnt_0, gnt_1, done_0, done_1, rdata_0, rdata_1, busy,
    input  addr_data_m, mem_we, in_data_m
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single port of the 256x32 data memory between the LSU (port 0)
//   and a DMA/debug master (port 1) using round-robin priority. Each access
//   runs IDLE/DONE -> ISSUE -> [WAIT] -> DONE, with a one-cycle GNT pulse in
//   ISSUE and a one-cycle DONE pulse when the access completes.
//
//   Ports
//     clk_i   : clock, all state changes on the rising edge
//     rst_ni  : synchronous active-low reset
//     bus     : dmem_arbiter_if.slave (requester ports + memory port)
//
//   Parameters
//     ADDR_W   : memory word-address width
//     DATA_W   : data width
//     READ_LAT : cycles from address presentation to valid read data (1..4)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  dmem_arbiter_if.slave         bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  // Value of the wait counter on the last WAIT cycle (READ_LAT-1 cycles total).
  localparam logic [1:0] WAIT_LAST = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;

  state_e            state_q, state_d;
  logic              pri_q, pri_d;
  logic              port_q, port_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic anyReq;
  logic winner;

  // A lone requester always wins; on a tie the priority pointer decides.
  assign anyReq = bus.req_0 | bus.req_1;
  assign winner = (bus.req_0 & bus.req_1) ? pri_q : bus.req_1;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pri_q    <= 1'b0;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= 2'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      pri_q    <= pri_d;
      port_q   <= port_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pri_d    = pri_q;
    port_d   = port_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    unique case (state_q)
      // IDLE and DONE are both arbitration points; the latched address and
      // write data go straight onto the memory bus for the ISSUE cycle.
      IDLE, DONE: begin
        if (anyReq) begin
          state_d = ISSUE;
          port_d  = winner;
          pri_d   = ~winner;
          we_d    = winner ? bus.we_1    : bus.we_0;
          addr_d  = winner ? bus.addr_1  : bus.addr_0;
          wdata_d = winner ? bus.wdata_1 : bus.wdata_0;
        end else begin
          state_d = IDLE;
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else if (READ_LAT == 1) begin
          state_d = DONE;
          if (port_q) rdata1_d = bus.out_data_m;
          else        rdata0_d = bus.out_data_m;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'd0;
        end
      end

      WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
          if (port_q) rdata1_d = bus.out_data_m;
          else        rdata0_d = bus.out_data_m;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt_0       = (state_q == ISSUE) & ~port_q;
  assign bus.gnt_1       = (state_q == ISSUE) &  port_q;
  assign bus.done_0      = (state_q == DONE)  & ~port_q;
  assign bus.done_1      = (state_q == DONE)  &  port_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.mem_we      = (state_q == ISSUE) & we_q;
  assign bus.addr_data_m = addr_q;
  assign bus.in_data_m   = wdata_q;
  assign bus.rdata_0     = rdata0_q;
  assign bus.rdata_1     = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Two arbiter instances share one clock: dutA with READ_LAT = 1 backed by a
//   combinational memory model, dutB with READ_LAT = 3 backed by a memory
//   model whose read data appears two edges after the address. Directed
//   stimulus pushes hand-computed GNT/DONE expectations (port, cycle, read
//   data) into queues; a negedge monitor pops and compares them.
//   cyc counts rising edges, so an access whose request is sampled at edge E0
//   shows GNT while cyc == E0 and DONE while cyc == E0 + 1 (write) or
//   E0 + READ_LAT (read).
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

  typedef struct {
    int          dut;
    int          port;
    int          cyc;
    bit          isRead;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rstA_n;
  logic rstB_n;
  int   cyc;
  int   nChecks;
  int   nFails;
  int   weCountA;
  int   weCountB;
  int   weBase;

  exp_t gntQ[$];
  exp_t doneQ[$];

  logic [31:0] memA [256];
  logic [31:0] memB [256];
  logic [31:0] pB1;
  logic [31:0] pB2;

  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) busA ();
  dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) busB ();

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(1)) dutA (
    .clk_i  (clk),
    .rst_ni (rstA_n),
    .bus    (busA)
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(32), .READ_LAT(3)) dutB (
    .clk_i  (clk),
    .rst_ni (rstB_n),
    .bus    (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: writes land mid-cycle while mem_we is high.
  assign busA.out_data_m = memA[busA.addr_data_m];

  always @(posedge clk) begin
    pB1 <= memB[busB.addr_data_m];
    pB2 <= pB1;
  end
  assign busB.out_data_m = pB2;

  always @(negedge clk) begin
    if (busA.mem_we) memA[busA.addr_data_m] = busA.in_data_m;
    if (busB.mem_we) memB[busB.addr_data_m] = busB.in_data_m;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    nChecks++;
    if (act !== req) begin
      nFails++;
      $display("[TB] FAIL %s: got %h, required %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic applyStimulus(input int d, input int port, input bit we,
                               input logic [7:0] addr, input logic [31:0] wdata,
                               input bit req);
    if (d == 0) begin
      if (port == 0) begin
        busA.req_0 = req; busA.we_0 = we; busA.addr_0 = addr; busA.wdata_0 = wdata;
      end else begin
        busA.req_1 = req; busA.we_1 = we; busA.addr_1 = addr; busA.wdata_1 = wdata;
      end
    end else begin
      if (port == 0) begin
        busB.req_0 = req; busB.we_0 = we; busB.addr_0 = addr; busB.wdata_0 = wdata;
      end else begin
        busB.req_1 = req; busB.we_1 = we; busB.addr_1 = addr; busB.wdata_1 = wdata;
      end
    end
  endtask

  task automatic expGnt(input int d, input int port, input int c);
    exp_t e;
    e.dut = d; e.port = port; e.cyc = c; e.isRead = 1'b0; e.rdata = 32'h0;
    gntQ.push_back(e);
  endtask

  task automatic expDone(input int d, input int port, input int c, input bit rd, input logic [31:0] v);
    exp_t e;
    e.dut = d; e.port = port; e.cyc = c; e.isRead = rd; e.rdata = v;
    doneQ.push_back(e);
  endtask

  task automatic monitorStep(input int d, input logic g0, input logic g1,
                             input logic dn0, input logic dn1,
                             input logic [31:0] r0, input logic [31:0] r1);
    exp_t e;
    if (g0 | g1) begin
      checkOutput("gnt onehot", 32'(g0 & g1), 32'h0);
      if (gntQ.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL unexpected gnt: dut%0d port %0d at cyc %0d, required none", d, g1, cyc);
      end else begin
        e = gntQ.pop_front();
        checkOutput("gnt dut",   32'(d),   32'(e.dut));
        checkOutput("gnt port",  32'(g1),  32'(e.port));
        checkOutput("gnt cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (dn0 | dn1) begin
      checkOutput("done onehot", 32'(dn0 & dn1), 32'h0);
      if (doneQ.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL unexpected done: dut%0d port %0d at cyc %0d, required none", d, dn1, cyc);
      end else begin
        e = doneQ.pop_front();
        checkOutput("done dut",   32'(d),   32'(e.dut));
        checkOutput("done port",  32'(dn1), 32'(e.port));
        checkOutput("done cycle", 32'(cyc), 32'(e.cyc));
        if (e.isRead) checkOutput("done rdata", dn1 ? r1 : r0, e.rdata);
      end
    end
  endtask

  // Scoreboard monitor: samples both arbiters on the falling edge.
  always @(negedge clk) begin
    monitorStep(0, busA.gnt_0, busA.gnt_1, busA.done_0, busA.done_1, busA.rdata_0, busA.rdata_1);
    monitorStep(1, busB.gnt_0, busB.gnt_1, busB.done_0, busB.done_1, busB.rdata_0, busB.rdata_1);
    if (busA.mem_we) weCountA++;
    if (busB.mem_we) weCountB++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b;

  initial begin
    cyc = 0; nChecks = 0; nFails = 0; weCountA = 0; weCountB = 0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = 32'h0;
      memB[i] = 32'h0;
    end
    memA[8'h20] = 32'hA0A0_A0A0;
    memA[8'h21] = 32'hB1B1_B1B1;
    memB[8'h05] = 32'h0505_0505;
    memB[8'hFF] = 32'hCAFE_F00D;

    applyStimulus(1, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    applyStimulus(1, 1, 1'b0, 8'h00, 32'h0, 1'b0);

    // Reset held for two edges with both ports requesting reads.
    rstA_n = 1'b0;
    rstB_n = 1'b0;
    applyStimulus(0, 0, 1'b0, 8'h20, 32'h0, 1'b1);
    applyStimulus(0, 1, 1'b0, 8'h21, 32'h0, 1'b1);
    tick(2);
    checkOutput("rst gnt_0",  32'(busA.gnt_0),  32'h0);
    checkOutput("rst gnt_1",  32'(busA.gnt_1),  32'h0);
    checkOutput("rst done_0", 32'(busA.done_0), 32'h0);
    checkOutput("rst done_1", 32'(busA.done_1), 32'h0);
    checkOutput("rst busy",   32'(busA.busy),   32'h0);
    checkOutput("rst mem_we", 32'(busA.mem_we), 32'h0);
    checkOutput("rst addr_data_m", 32'(busA.addr_data_m), 32'h0);
    checkOutput("rst in_data_m",   busA.in_data_m, 32'h0);
    checkOutput("rst rdata_0",     busA.rdata_0,   32'h0);
    checkOutput("rst rdata_1",     busA.rdata_1,   32'h0);
    checkOutput("rst B busy",      32'(busB.busy), 32'h0);

    // Release: port 0 goes first, the pending port 1 follows.
    rstA_n = 1'b1;
    rstB_n = 1'b1;
    b = cyc;
    expGnt(0, 0, b + 1); expDone(0, 0, b + 2, 1'b1, 32'hA0A0_A0A0);
    expGnt(0, 1, b + 3); expDone(0, 1, b + 4, 1'b1, 32'hB1B1_B1B1);
    tick(2); applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2); applyStimulus(0, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2);
    checkOutput("idle busy", 32'(busA.busy), 32'h0);

    // Port 0 write then read of 0x10, then port 1 reads it too.
    b = cyc; weBase = weCountA;
    applyStimulus(0, 0, 1'b1, 8'h10, 32'hDEAD_BEEF, 1'b1);
    expGnt(0, 0, b + 1); expDone(0, 0, b + 2, 1'b0, 32'h0);
    tick(2); applyStimulus(0, 0, 1'b0, 8'h10, 32'h0, 1'b1);
    expGnt(0, 0, b + 3); expDone(0, 0, b + 4, 1'b1, 32'hDEAD_BEEF);
    tick(2); applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    applyStimulus(0, 1, 1'b0, 8'h10, 32'h0, 1'b1);
    expGnt(0, 1, b + 5); expDone(0, 1, b + 6, 1'b1, 32'hDEAD_BEEF);
    tick(2); applyStimulus(0, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2);
    checkOutput("single write mem_we cycles", 32'(weCountA - weBase), 32'd1);
    checkOutput("rdata_0 after read", busA.rdata_0, 32'hDEAD_BEEF);

    // Simultaneous writes, then simultaneous read-back.
    b = cyc; weBase = weCountA;
    applyStimulus(0, 0, 1'b1, 8'h01, 32'h1111_1111, 1'b1);
    applyStimulus(0, 1, 1'b1, 8'h02, 32'h2222_2222, 1'b1);
    expGnt(0, 0, b + 1); expDone(0, 0, b + 2, 1'b0, 32'h0);
    expGnt(0, 1, b + 3); expDone(0, 1, b + 4, 1'b0, 32'h0);
    tick(2); applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2);
    applyStimulus(0, 0, 1'b0, 8'h01, 32'h0, 1'b1);
    applyStimulus(0, 1, 1'b0, 8'h02, 32'h0, 1'b1);
    expGnt(0, 0, b + 5); expDone(0, 0, b + 6, 1'b1, 32'h1111_1111);
    expGnt(0, 1, b + 7); expDone(0, 1, b + 8, 1'b1, 32'h2222_2222);
    tick(2); applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2); applyStimulus(0, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2);
    checkOutput("simultaneous mem_we cycles", 32'(weCountA - weBase), 32'd2);

    // Fairness: both ports hold write requests for eight grants.
    b = cyc; weBase = weCountA;
    applyStimulus(0, 0, 1'b1, 8'h30, 32'h3030_3030, 1'b1);
    applyStimulus(0, 1, 1'b1, 8'h31, 32'h3131_3131, 1'b1);
    for (int i = 0; i < 8; i++) begin
      expGnt(0, i % 2, b + 1 + 2 * i);
      expDone(0, i % 2, b + 2 + 2 * i, 1'b0, 32'h0);
    end
    tick(16);
    applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    applyStimulus(0, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(2);
    checkOutput("fairness mem_we cycles", 32'(weCountA - weBase), 32'd8);
    checkOutput("rdata_0 held over writes", busA.rdata_0, 32'h1111_1111);
    checkOutput("rdata_1 held over writes", busA.rdata_1, 32'h2222_2222);
    checkOutput("mem 0x31 written", memA[8'h31], 32'h3131_3131);

    // Reset on the edge that ends a write ISSUE: no DONE, mem_we drops.
    b = cyc;
    applyStimulus(0, 0, 1'b1, 8'h40, 32'h4444_4444, 1'b1);
    expGnt(0, 0, b + 1);
    tick(1);
    checkOutput("mem_we in write issue", 32'(busA.mem_we), 32'h1);
    applyStimulus(0, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    rstA_n = 1'b0;
    tick(1);
    checkOutput("mem_we after reset", 32'(busA.mem_we), 32'h0);
    checkOutput("busy after reset",   32'(busA.busy),   32'h0);
    checkOutput("rdata_0 after reset", busA.rdata_0,    32'h0);
    tick(1); rstA_n = 1'b1;
    tick(2);
    checkOutput("idle after reset", 32'(busA.busy), 32'h0);

    // READ_LAT = 3: port 0 read, then port 1 read of 0xFF.
    b = cyc; weBase = weCountB;
    applyStimulus(1, 0, 1'b0, 8'h05, 32'h0, 1'b1);
    expGnt(1, 0, b + 1); expDone(1, 0, b + 4, 1'b1, 32'h0505_0505);
    tick(2); applyStimulus(1, 0, 1'b0, 8'h00, 32'h0, 1'b0);
    checkOutput("B busy in wait",   32'(busB.busy),   32'h1);
    checkOutput("B mem_we in wait", 32'(busB.mem_we), 32'h0);
    tick(4);
    b = cyc;
    applyStimulus(1, 1, 1'b0, 8'hFF, 32'h0, 1'b1);
    expGnt(1, 1, b + 1); expDone(1, 1, b + 4, 1'b1, 32'hCAFE_F00D);
    tick(2); applyStimulus(1, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    tick(4);
    checkOutput("B mem_we cycles", 32'(weCountB - weBase), 32'd0);
    checkOutput("B rdata_0 unchanged", busB.rdata_0, 32'h0505_0505);
    checkOutput("B rdata_1", busB.rdata_1, 32'hCAFE_F00D);

    // Reset during WAIT: access aborted, read data cleared.
    b = cyc;
    applyStimulus(1, 1, 1'b0, 8'hFF, 32'h0, 1'b1);
    expGnt(1, 1, b + 1);
    tick(2);
    applyStimulus(1, 1, 1'b0, 8'h00, 32'h0, 1'b0);
    checkOutput("B busy before abort", 32'(busB.busy), 32'h1);
    rstB_n = 1'b0;
    tick(1);
    checkOutput("B busy after abort",    32'(busB.busy),   32'h0);
    checkOutput("B done_1 after abort",  32'(busB.done_1), 32'h0);
    checkOutput("B rdata_0 after abort", busB.rdata_0,     32'h0);
    checkOutput("B rdata_1 after abort", busB.rdata_1,     32'h0);
    tick(1); rstB_n = 1'b1;
    tick(4);
    checkOutput("B idle after abort", 32'(busB.busy), 32'h0);

    checkOutput("gnt queue drained",  32'(gntQ.size()),  32'h0);
    checkOutput("done queue drained", 32'(doneQ.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
